// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the cpu_sequencer slice: opcodes, field positions, FSM states.
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN (adds the PAUSE state).
package cpu_sequencer_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_JMP    = 4'h8;
  localparam logic [3:0] OP_BZ     = 4'h9;
  localparam logic [3:0] OP_ILL_LO = 4'hA;
  localparam logic [3:0] OP_ILL_HI = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam int FLD_OP_LSB  = 28;
  localparam int FLD_RD_LSB  = 24;
  localparam int FLD_RS1_LSB = 20;
  localparam int FLD_RS2_LSB = 16;
  localparam int FLD_TGT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    ST_HALT      = 3'd5,
    ST_PAUSE     = 3'd6
`else
    ST_HALT      = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/cpu_sequencer_decode.sv
// seq_decode: purely combinational split of the instruction register into
// register-file addresses, jump target and instruction-class flags.
module seq_decode
  import cpu_sequencer_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 6
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         op,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [PC_W-1:0]    target,
  output logic               is_alu,
  output logic               is_jmp,
  output logic               is_bz,
  output logic               is_halt,
  output logic               is_illegal
);

  // Bits between rs2 and the target field carry no meaning for the sequencer.
  logic unused_bits;

  assign op     = ir[FLD_OP_LSB  +: 4];
  assign rd     = ir[FLD_RD_LSB  +: 4];
  assign rs1    = ir[FLD_RS1_LSB +: 4];
  assign rs2    = ir[FLD_RS2_LSB +: 4];
  assign target = ir[FLD_TGT_LSB +: PC_W];

  assign unused_bits = ^ir[FLD_RS2_LSB-1:PC_W];

  assign is_alu     = (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  assign is_jmp     = (op == OP_JMP);
  assign is_bz      = (op == OP_BZ);
  assign is_halt    = (op == OP_HALT);
  assign is_illegal = (op >= OP_ILL_LO) && (op <= OP_ILL_HI);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute/writeback controller owning PC and IR.
// Define CPU_SEQ_SINGLE_STEP_EN to add the `step` input and the PAUSE state:
// every transition that would enter FETCH parks in PAUSE until step is high.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W     = 6,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_ready,
  input  logic               zero_flag,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         alu_op,
  output logic [3:0]         rd_addr,
  output logic [3:0]         rs1_addr,
  output logic [3:0]         rs2_addr,
  output logic               alu_en,
  output logic               reg_we,
  output logic               halted,
  output logic               illegal
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam state_t ST_NEXT = ST_PAUSE;
`else
  localparam state_t ST_NEXT = ST_FETCH;
`endif

  state_t          state;
  logic [PC_W-1:0] target;
  logic            is_alu, is_jmp, is_bz, is_halt, is_illegal;

  seq_decode #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_dec (
    .ir         (ir),
    .op         (alu_op),
    .rd         (rd_addr),
    .rs1        (rs1_addr),
    .rs2        (rs2_addr),
    .target     (target),
    .is_alu     (is_alu),
    .is_jmp     (is_jmp),
    .is_bz      (is_bz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Sequencer FSM; strobes are registered on the transition into the state
  // they belong to, so alu_en is high throughout EXECUTE and reg_we throughout WRITEBACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= PC_RST;
      ir      <= '0;
      alu_en  <= 1'b0;
      reg_we  <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_NEXT;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            ir    <= instr_in;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_illegal) illegal <= 1'b1;
          if (is_alu)     alu_en  <= 1'b1;
          state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (is_alu) begin
            reg_we <= 1'b1;
            state  <= ST_WRITEBACK;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            if (is_jmp)                  pc <= target;
            else if (is_bz && zero_flag) pc <= target;
            else                         pc <= pc + PC_ONE;
            state <= ST_NEXT;
          end
        end
        ST_WRITEBACK: begin
          pc    <= pc + PC_ONE;
          state <= ST_NEXT;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
`ifdef CPU_SEQ_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (step) state <= ST_FETCH;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: reset/timing sequences, a directed
// per-instruction table, and random programs against an instruction-level model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready, zero_flag;
  logic [31:0] instr_in;
  logic [5:0]  pc;
  logic [31:0] ir;
  logic [3:0]  alu_op, rd_addr, rs1_addr, rs2_addr;
  logic        alu_en, reg_we, halted, illegal;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic        step;
`endif

  logic [31:0] mem [64];
  logic        zf_tab [64];
  logic        use_tab, zf_const;
  int          total, bad;

  always #5 clk = ~clk;

  always_comb instr_in  = mem[pc];
  always_comb zero_flag = use_tab ? zf_tab[pc] : zf_const;

  cpu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .instr_in  (instr_in),
    .mem_ready (mem_ready),
    .zero_flag (zero_flag),
    .pc        (pc),
    .ir        (ir),
    .alu_op    (alu_op),
    .rd_addr   (rd_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .alu_en    (alu_en),
    .reg_we    (reg_we),
    .halted    (halted),
    .illegal   (illegal)
  );

  typedef struct {
    logic [5:0]  at;
    logic [31:0] instr;
    logic        zf;
    logic [5:0]  npc;
    logic        wb;
    logic [3:0]  rd;
    logic        ill;
    logic        hlt;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [5:0] tgt);
    return {op, rd, rs1, rs2, 10'd0, tgt};
  endfunction

  task automatic clear_mem;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = mk(4'h0, 4'h0, 4'h0, 4'h0, 6'd0);
      zf_tab[i] = 1'b0;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
  endtask

  // Instruction-level reference: what one instruction at address p does.
  function automatic void model_step(input logic [5:0] p, input logic zf,
                                     output logic [5:0] np, output bit wb,
                                     output logic [3:0] rd, output bit hlt, output bit ill);
    int op;
    op  = int'(mem[p][31:28]);
    rd  = mem[p][27:24];
    wb  = 0;
    hlt = 0;
    ill = (op >= 10 && op <= 14);
    np  = p + 6'd1;
    if (op >= 1 && op <= 7) wb = 1;
    else if (op == 8)       np = mem[p][5:0];
    else if (op == 9 && zf) np = mem[p][5:0];
    else if (op == 15) begin
      hlt = 1;
      np  = p;
    end
  endfunction

  initial begin
    int           wcnt, acnt, both;
    logic [3:0]   wrd;
    bit           done;
    logic [5:0]   prev_pc, p, np, halt_pc;
    bit           wb, hlt, ill, exp_ill, exp_halt;
    logic [3:0]   rd;
    logic [5:0]   pcq [$];
    logic [9:0]   wbq [$];
    logic [9:0]   ent;
    logic [3:0]   rop;
    logic [5:0]   rtgt;

    total = 0; bad = 0;
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; use_tab = 1'b0; zf_const = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    clear_mem();

    // ---- reset state and cycle-exact first ALU instruction ----
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_strobes", {alu_en, reg_we}, 0);
    check("rst_flags", {halted, illegal}, 0);
`ifndef CPU_SEQ_SINGLE_STEP_EN
    mem[0] = mk(4'h1, 4'h2, 4'h3, 4'h4, 6'd0);
    mem_ready = 1'b1;
    run = 1'b1;
    tick; check("c1_fetch_pc", pc, 0);  check("c1_strobes", {alu_en, reg_we}, 0);
    tick; check("c2_ir", ir, mem[0]);   check("c2_alu_op", alu_op, 1);
          check("c2_alu_en", alu_en, 0);
    tick; check("c3_alu_en", {alu_en, reg_we}, 2'b10);
    tick; check("c4_reg_we", {alu_en, reg_we}, 2'b01); check("c4_rd", rd_addr, 2);
          check("c4_rs", {rs1_addr, rs2_addr}, 8'h34);
    tick; check("c5_pc", pc, 1);        check("c5_reg_we", reg_we, 0);
`endif

    // ---- fetch stall: mem_ready low for 5 cycles ----
    do_reset();
    clear_mem();
    mem[0] = mk(4'h3, 4'h6, 4'h1, 4'h2, 6'd0);
    mem_ready = 1'b0;
    run = 1'b1;
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      check("stall_pc_ir", {ir, 2'b00, pc}, 0);
      check("stall_strobes", {alu_en, reg_we}, 0);
      tick;
    end
    mem_ready = 1'b1;
    tick;
    check("stall_ir_load", ir, mem[0]);

    // ---- directed per-instruction table ----
    vt[0]  = '{6'd0,  mk(4'h1, 4'h2, 4'h0, 4'h0, 6'd0),  1'b0, 6'd1,  1'b1, 4'h2, 1'b0, 1'b0};
    vt[1]  = '{6'd20, mk(4'h7, 4'hF, 4'h1, 4'h1, 6'd0),  1'b0, 6'd21, 1'b1, 4'hF, 1'b0, 1'b0};
    vt[2]  = '{6'd5,  mk(4'h8, 4'h0, 4'h0, 4'h0, 6'h2A), 1'b0, 6'h2A, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[3]  = '{6'd7,  mk(4'h9, 4'h0, 4'h0, 4'h0, 6'h10), 1'b1, 6'h10, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[4]  = '{6'd7,  mk(4'h9, 4'h0, 4'h0, 4'h0, 6'h10), 1'b0, 6'd8,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[5]  = '{6'd63, mk(4'h0, 4'h0, 4'h0, 4'h0, 6'd5),  1'b0, 6'd0,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[6]  = '{6'd9,  mk(4'hC, 4'h1, 4'h0, 4'h0, 6'd3),  1'b0, 6'd10, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[7]  = '{6'd30, mk(4'hA, 4'h3, 4'h0, 4'h0, 6'd0),  1'b1, 6'd31, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[8]  = '{6'd40, mk(4'hE, 4'h0, 4'h0, 4'h0, 6'd0),  1'b0, 6'd41, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[9]  = '{6'd12, mk(4'hF, 4'h0, 4'h0, 4'h0, 6'd0),  1'b0, 6'd12, 1'b0, 4'h0, 1'b0, 1'b1};
    vt[10] = '{6'd0,  mk(4'h8, 4'h0, 4'h0, 4'h0, 6'h3F), 1'b0, 6'h3F, 1'b0, 4'h0, 1'b0, 1'b0};

    for (int v = 0; v < 11; v++) begin
      do_reset();
      clear_mem();
      if (vt[v].at != 6'd0) mem[0] = mk(4'h8, 4'h0, 4'h0, 4'h0, vt[v].at);
      mem[vt[v].at] = vt[v].instr;
      zf_const  = vt[v].zf;
      use_tab   = 1'b0;
      mem_ready = 1'b1;
      run       = 1'b1;
      done = 0;
      for (int c = 0; c < 30 && !done; c++) begin
        tick;
        if (pc == vt[v].at) done = 1;
      end
      if (vt[v].at == 6'd0) done = 1;
      check($sformatf("vec%0d_reach", v), done, 1);
      wcnt = 0; acnt = 0; both = 0; wrd = 4'h0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        tick;
        if (reg_we) begin wcnt++; wrd = rd_addr; end
        if (alu_en) acnt++;
        if (alu_en && reg_we) both++;
        if (pc != vt[v].at || halted) done = 1;
      end
      if (vt[v].hlt) repeat (3) tick;
      check($sformatf("vec%0d_done", v), done, 1);
      check($sformatf("vec%0d_pc", v), pc, vt[v].npc);
      check($sformatf("vec%0d_we_cnt", v), wcnt, vt[v].wb);
      check($sformatf("vec%0d_alu_cnt", v), acnt, vt[v].wb);
      check($sformatf("vec%0d_overlap", v), both, 0);
      if (vt[v].wb) check($sformatf("vec%0d_rd", v), wrd, vt[v].rd);
      check($sformatf("vec%0d_illegal", v), illegal, vt[v].ill);
      check($sformatf("vec%0d_halted", v), halted, vt[v].hlt);
    end

    // ---- illegal is sticky, HALT freezes, reset recovers ----
    do_reset();
    clear_mem();
    mem[0] = mk(4'hC, 4'h0, 4'h0, 4'h0, 6'd0);
    mem[1] = mk(4'hF, 4'h0, 4'h0, 4'h0, 6'd0);
    mem_ready = 1'b1;
    run = 1'b1;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick;
      if (halted) done = 1;
    end
    check("halt_reached", done, 1);
    check("halt_illegal_sticky", illegal, 1);
    for (int c = 0; c < 20; c++) begin
      run = 1'($urandom_range(0, 1));
      tick;
      check("halt_frozen", {pc, halted, alu_en, reg_we}, {6'd1, 3'b100});
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    run = 1'b0;
    check("halt_rst_pc_ir", {ir, 2'b00, pc}, 0);
    check("halt_rst_flags", {halted, illegal, alu_en, reg_we}, 0);
    repeat (4) tick;
    check("idle_hold", {ir, 2'b00, pc}, 0);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    // ---- single step: two pulses execute exactly two instructions ----
    step = 1'b0;
    do_reset();
    clear_mem();
    mem[0] = mk(4'h1, 4'h3, 4'h0, 4'h0, 6'd0);
    mem[1] = mk(4'h2, 4'h4, 4'h0, 4'h0, 6'd0);
    mem[2] = mk(4'h3, 4'h5, 4'h0, 4'h0, 6'd0);
    mem_ready = 1'b1;
    run = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 2; k++) begin
      repeat (8) begin tick; if (reg_we) wcnt++; end
      step = 1'b1; tick; if (reg_we) wcnt++;
      step = 1'b0;
    end
    repeat (15) begin tick; if (reg_we) wcnt++; end
    check("step_we_count", wcnt, 2);
    check("step_paused_pc", pc, 2);
    check("step_paused_quiet", {alu_en, reg_we}, 0);
    step = 1'b1;
`endif

    // ---- random programs against the instruction-level model ----
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 64; i++) begin
        rop  = 4'($urandom_range(0, 15));
        if (rop == 4'hF && $urandom_range(0, 3) != 0) rop = 4'h0;
        rtgt = 6'($urandom_range(0, 63));
        if (rtgt == 6'(i)) rtgt = rtgt + 6'd1;
        mem[i]    = mk(rop, 4'($urandom_range(0, 15)), 4'h0, 4'h0, rtgt);
        zf_tab[i] = 1'($urandom_range(0, 1));
      end
      use_tab = 1'b1;
      pcq.delete(); wbq.delete();
      p = 6'd0; exp_ill = 0; exp_halt = 0; halt_pc = 6'd0;
      for (int k = 0; k < 40 && !exp_halt; k++) begin
        model_step(p, zf_tab[p], np, wb, rd, hlt, ill);
        if (ill) exp_ill = 1;
        if (wb) wbq.push_back({p, rd});
        if (hlt) begin exp_halt = 1; halt_pc = p; end
        else begin pcq.push_back(np); p = np; end
      end
      prev_pc = pc;
      done = 0;
      for (int c = 0; c < 2500 && !done; c++) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        run = 1'($urandom_range(0, 1));
        tick;
        if (reg_we) begin
          check("rnd_overlap", alu_en, 0);
          if (wbq.size() > 0) begin
            ent = wbq.pop_front();
            check("rnd_we_pc", pc, ent[9:4]);
            check("rnd_we_rd", rd_addr, ent[3:0]);
          end else if (pcq.size() > 0) begin
            check("rnd_extra_we", 1, 0);
          end
        end
        if (pc != prev_pc && pcq.size() > 0) begin
          check("rnd_pc", pc, pcq.pop_front());
          if (pcq.size() == 0 && !exp_halt) begin
            check("rnd_illegal", illegal, exp_ill);
            check("rnd_we_left", wbq.size(), 0);
            done = 1;
          end
        end
        prev_pc = pc;
        if (exp_halt && pcq.size() == 0 && halted) begin
          check("rnd_halt_pc", pc, halt_pc);
          check("rnd_halt_illegal", illegal, exp_ill);
          check("rnd_halt_we_left", wbq.size(), 0);
          done = 1;
        end
      end
      check($sformatf("rnd%0d_finished", r), done, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
